// File: rtl/lsu_sram_master.sv
// rtl/lsu_sram_master.sv - single-outstanding load/store initiator for the SRAM data port
module lsu_sram_master #(
    parameter logic [31:0] SRAM_SIZE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] sram_addr,
    output logic [31:0] w_sram,
    output logic        w_sram_en,
    input  logic [31:0] r_sram
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic [1:0]  addr_lo;
    logic [1:0]  size_q;
    logic        write_q;
    logic        signed_q;
    logic [15:0] wdata_q;

    // Word stores go straight to WR, so only the sub-word part of wdata is kept.
    logic [32:0] end_addr;
    logic        fault;

    always_comb begin
        end_addr = {1'b0, req_addr} + (33'd1 << req_size);
        fault    = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                 | (end_addr > {1'b0, SRAM_SIZE});
    end

    function automatic logic [31:0] merge_word(input logic [31:0] word,
                                               input logic [15:0] wd,
                                               input logic [1:0]  lo,
                                               input logic        half);
        logic [31:0] w;
        w = word;
        if (half)
            w[{lo[1], 4'b0000} +: 16] = wd;
        else
            w[{lo, 3'b000} +: 8] = wd[7:0];
        return w;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [1:0]  lo,
                                            input logic [1:0]  size,
                                            input logic        sgn);
        logic [31:0] sh;
        logic [31:0] r;
        case (size)
            2'b00: begin
                sh = word >> {lo, 3'b000};
                r  = {{24{sgn & sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh = word >> {lo[1], 4'b0000};
                r  = {{16{sgn & sh[15]}}, sh[15:0]};
            end
            default: begin
                sh = word;
                r  = word;
            end
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_lo   <= 2'b00;
            size_q    <= 2'b00;
            write_q   <= 1'b0;
            signed_q  <= 1'b0;
            wdata_q   <= 16'h0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_fault <= 1'b0;
            sram_addr <= 32'h0;
            w_sram    <= 32'h0;
            w_sram_en <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            w_sram    <= 32'h0;
            w_sram_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_lo   <= req_addr[1:0];
                        size_q    <= req_size;
                        write_q   <= req_write;
                        signed_q  <= req_signed;
                        wdata_q   <= req_wdata[15:0];
                        req_ready <= 1'b0;
                        rsp_rdata <= 32'h0;
                        if (fault) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                        end else begin
                            rsp_fault <= 1'b0;
                            sram_addr <= {req_addr[31:2], 2'b00};
                            if (req_write && req_size == 2'b10) begin
                                state     <= WR;
                                w_sram    <= req_wdata;
                                w_sram_en <= 1'b1;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (write_q) begin
                        state     <= WR;
                        w_sram    <= merge_word(r_sram, wdata_q, addr_lo, size_q[0]);
                        w_sram_en <= 1'b1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= extract(r_sram, addr_lo, size_q, signed_q);
                        sram_addr <= 32'h0;
                    end
                end
                WR: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    sram_addr <= 32'h0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_rdata <= 32'h0;
                    rsp_fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_sram_master.sv
// tb/tb_lsu_sram_master.sv - randomized and directed checks against a byte-array memory model
module tb_lsu_sram_master;

    localparam logic [31:0] SRAM_SIZE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] sram_addr;
    logic [31:0] w_sram;
    logic        w_sram_en;
    logic [31:0] r_sram;

    logic [31:0] mem [0:1023];
    logic [7:0]  ref_b [0:4095];

    int n_checks = 0;
    int n_pass = 0;

    lsu_sram_master #(.SRAM_SIZE(SRAM_SIZE)) dut (
        .clk(clk), .rst(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .sram_addr(sram_addr), .w_sram(w_sram),
        .w_sram_en(w_sram_en), .r_sram(r_sram)
    );

    always #5 clk = ~clk;

    assign r_sram = mem[sram_addr[11:2]];

    always @(posedge clk) begin
        if (w_sram_en) mem[sram_addr[11:2]] <= w_sram;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        mem[a[11:2]] = w;
        for (int i = 0; i < 4; i++) ref_b[{a[11:2], 2'b00} + i] = w[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_b[{a[11:2], 2'b00} + i];
        return w;
    endfunction

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd);
        int          nbytes;
        logic        e_fault;
        logic [31:0] e_rdata;
        logic [31:0] e_word;
        int          e_lat;
        int          cyc;
        int          wen_cnt;
        logic        got;
        logic        ready_bad;
        logic        word_bad;

        nbytes  = 1 << sz;
        e_fault = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0)
                  || ({1'b0, a} + 33'(nbytes) > {1'b0, SRAM_SIZE});
        e_rdata = 32'h0;
        e_word  = 32'h0;
        if (e_fault)
            e_lat = 1;
        else if (!wr || sz == 2'd2)
            e_lat = 2;
        else
            e_lat = 3;
        if (!e_fault && !wr) begin
            for (int i = 0; i < nbytes; i++) e_rdata[8*i +: 8] = ref_b[a + i];
            if (sg && sz == 2'd0 && e_rdata[7])  e_rdata[31:8]  = 24'hFFFFFF;
            if (sg && sz == 2'd1 && e_rdata[15]) e_rdata[31:16] = 16'hFFFF;
        end
        if (!e_fault && wr) begin
            for (int i = 0; i < nbytes; i++) ref_b[a + i] = wd[8*i +: 8];
            e_word = ref_word(a);
        end

        @(negedge clk);
        chk({tag, " ready_before"}, req_ready, 1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        cyc = 1; wen_cnt = 0; got = 0; ready_bad = 0; word_bad = 0;
        while (cyc <= 8) begin
            if (req_ready !== 1'b0) ready_bad = 1;
            if (w_sram_en === 1'b1) begin
                wen_cnt++;
                if (w_sram !== e_word || sram_addr !== {a[31:2], 2'b00}) word_bad = 1;
            end
            if (rsp_valid === 1'b1) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " got_rsp"}, got, 1);
        chk({tag, " latency"}, cyc, e_lat);
        chk({tag, " fault"}, rsp_fault, e_fault);
        chk({tag, " rdata"}, rsp_rdata, e_rdata);
        chk({tag, " wen_count"}, wen_cnt, (wr && !e_fault) ? 1 : 0);
        chk({tag, " wr_word_ok"}, word_bad, 0);
        chk({tag, " ready_low_busy"}, ready_bad, 0);
        @(posedge clk); #1;
        chk({tag, " rsp_pulse"}, rsp_valid, 0);
        chk({tag, " ready_after"}, req_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) preload(32'(i * 4), $urandom);

        #12;
        chk("reset ready", req_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset w_sram_en", w_sram_en, 0);
        chk("reset sram_addr", sram_addr, 0);
        chk("reset w_sram", w_sram, 0);
        chk("reset rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req("word_store", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        chk("word_store mem", mem[4], 32'hDEADBEEF);

        preload(32'h10, 32'h11223344);
        do_req("byte_store", 1, 2'd0, 0, 32'h13, 32'h000000AA);
        chk("byte_store mem", mem[4], 32'hAA223344);

        preload(32'h10, 32'h80011234);
        do_req("ld_half_s", 0, 2'd1, 1, 32'h12, 32'h0);
        do_req("ld_byte_u", 0, 2'd0, 0, 32'h11, 32'h0);
        do_req("ld_byte_s", 0, 2'd0, 1, 32'h13, 32'h0);
        do_req("ld_word", 0, 2'd2, 1, 32'h10, 32'h0);

        do_req("mis_word_ld", 0, 2'd2, 0, 32'h02, 32'h0);
        do_req("oor_word_st", 1, 2'd2, 0, SRAM_SIZE - 2, 32'h12345678);
        do_req("mis_half_st", 1, 2'd1, 0, 32'h21, 32'h0000BEEF);
        do_req("size3", 0, 2'd3, 0, 32'h20, 32'h0);
        do_req("half_oor", 0, 2'd1, 0, SRAM_SIZE, 32'h0);
        do_req("last_word_st", 1, 2'd2, 0, SRAM_SIZE - 4, 32'hCAFEF00D);
        do_req("last_byte_ld", 0, 2'd0, 1, SRAM_SIZE - 1, 32'h0);
        do_req("half_store", 1, 2'd1, 0, 32'h32, 32'h0000A5A5);

        // Back-to-back with req_valid held high.
        preload(32'h40, 32'h01020304);
        preload(32'h44, 32'hA0B0C0D0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h40;
        @(posedge clk); #1;
        req_addr = 32'h44;
        chk("b2b c1 ready", req_ready, 0);
        chk("b2b c1 rsp", rsp_valid, 0);
        @(posedge clk); #1;
        chk("b2b c2 ready", req_ready, 0);
        chk("b2b c2 rsp", rsp_valid, 1);
        chk("b2b c2 data", rsp_rdata, 32'h01020304);
        @(posedge clk); #1;
        chk("b2b c3 ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b c4 ready", req_ready, 0);
        @(posedge clk); #1;
        chk("b2b c5 rsp", rsp_valid, 1);
        chk("b2b c5 data", rsp_rdata, 32'hA0B0C0D0);
        @(posedge clk); #1;

        // Reset pulsed during the WR cycle of a byte store.
        preload(32'h50, 32'h55667788);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h51;
        req_wdata = 32'h000000EE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst wr_en_before", w_sram_en, 1);
        rst_n = 1'b0;
        #1;
        chk("rst wr_en_drop", w_sram_en, 0);
        chk("rst ready", req_ready, 1);
        chk("rst rsp", rsp_valid, 0);
        @(posedge clk); #1;
        chk("rst no_rsp", rsp_valid, 0);
        chk("rst mem_kept", mem[20], 32'h55667788);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst no_rsp_after", rsp_valid, 0);
        do_req("post_rst_ld", 0, 2'd2, 0, 32'h50, 32'h0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, 32'(SRAM_SIZE) + 8);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req("rand", 1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== ref_word(32'(i * 4))) begin
                chk("final mem", mem[i], ref_word(32'(i * 4)));
                break;
            end
        end
        chk("final mem0", mem[0], ref_word(32'h0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/lsu_sram_master.md
Name: lsu_sram_master

Overview:
- Load/store initiator for the core's SRAM data port: takes one CPU data request at a time and drives the memory's sram_addr/w_sram/w_sram_en inputs, sampling its combinational r_sram read port.
- Memory writes are always full 32-bit words, so byte/halfword stores are done as read-modify-write.
- Loads are zero- or sign-extended. Misaligned and out-of-range accesses are faulted before any memory access.
- Sits between the execute stage and the SRAM port of the memory block.

Parameters:
- SRAM_SIZE, 32'h0000_1000, SRAM size in bytes; any access with addr+bytes > SRAM_SIZE faults.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  in  1  sign-extend load result (ignored for word and for stores)
- req_addr  in  32  SRAM-relative byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores/faults
- rsp_fault  out  1  access rejected, valid with rsp_valid
- sram_addr  out  32  word-aligned address to memory (req_addr & ~3)
- w_sram  out  32  write word to memory
- w_sram_en  out  1  memory write strobe, one cycle per store
- r_sram  in  32  combinational read word from memory at sram_addr

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except req_ready=1. Request registers are cleared.
- Reset mid-operation: abandons the access with no response. w_sram_en drops immediately (asynchronous).
- Handshake: a request is accepted when req_valid & req_ready on a rising edge. req_ready = (state==IDLE).
- On accept, the block registers addr, size, write, signed and wdata. Request inputs are don't-care afterwards.
- rsp_valid is a single-cycle pulse with no backpressure. req_ready returns to 1 in the cycle after rsp_valid.
- sram_addr is held at {addr[31:2],2'b00} in RD and WR, and is 0 in IDLE/RESP.
- Fault check, evaluated at accept:
  - size==11 faults.
  - Halfword with addr[0]!=0 faults.
  - Word with addr[1:0]!=0 faults.
  - addr + (1<<size) > SRAM_SIZE faults; compute in 33 bits so there is no wrap.
- States: IDLE, RD, WR, RESP.
- Transitions from IDLE on accept:
  - Fault → RESP, rsp_fault=1.
  - Load → RD.
  - Word store → WR.
  - Byte/halfword store → RD.
- RD: one cycle. Captures r_sram into a data register. Load → RESP; store → WR.
- WR: one cycle, w_sram_en=1.
  - Word store: w_sram = wdata.
  - Byte store: w_sram = captured word with lane addr[1:0] replaced by wdata[7:0].
  - Halfword store: w_sram = captured word with lane addr[1] replaced by wdata[15:0].
  - Next state RESP.
- RESP: rsp_valid=1 for one cycle, then IDLE.
  - Load extraction: byte = word >> (8*addr[1:0]); halfword = word >> (16*addr[1]).
  - Extension: zero-extended, or sign-extended when signed=1.
- Latency, accept edge to rsp_valid cycle: fault 1; load 2; word store 2; sub-word store 3.
- w_sram_en is never asserted for loads or faults. w_sram = 0 outside WR.

Test Plan:
- Word store at addr 0x10, wdata 0xDEADBEEF:
  - WR cycle shows sram_addr=0x10, w_sram=0xDEADBEEF, w_sram_en=1 for exactly 1 cycle.
  - rsp_valid follows with fault=0.
- Byte store at addr 0x13, wdata 0x000000AA, memory word 0x11223344:
  - RD then WR with w_sram=0xAA223344.
  - rsp_valid 3 cycles after accept.
- Loads from addr 0x12, memory word 0x80011234:
  - Signed halfword load → rsp_rdata=0xFFFF8001.
  - Unsigned byte load at 0x11 → rsp_rdata=0x00000012.
- Misaligned word load at 0x02 and out-of-range word store at SRAM_SIZE-2:
  - Each gives rsp_fault=1 one cycle after accept.
  - w_sram_en stays 0 and rsp_rdata=0.
- Back-to-back requests with req_valid held high: second accepted only on the cycle after rsp_valid. req_ready=0 throughout RD/WR/RESP.
- rst pulsed low during WR of a byte store:
  - w_sram_en falls immediately and no rsp_valid is produced.
  - After release, req_ready=1 and a word load completes normally.
